sdram_arbiter: RTL and testbench

// Shares the single Gowin SDRAM controller command port (I_sdrc_* / O_sdrc_*) between two

---
 rtl/sdram_arbiter_pkg.sv | 23 ++
 rtl/sdram_arbiter_rr_pick2.sv | 12 +
 rtl/sdram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the SDRAM command-port arbiter: controller command codes and arbiter states.
package sdram_pkg;

    localparam int unsigned SdrcDataLenBitWidth = 8;

    typedef enum logic [2:0] {
        SdrcActivate = 3'b011,
        SdrcWrite    = 3'b100,
        SdrcRead     = 3'b101
    } sdrc_cmd_e;

    typedef enum logic [1:0] {
        Idle,
        Grant0,
        Grant1,
        Turnaround
    } arb_state_e;

    function automatic logic [1:0] gnt_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master not served last.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       pick_o,
    output logic       valid_o
);

    assign valid_o = |req_i;
    assign pick_o  = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of the Gowin SDRAM controller command port.
// Optional grant watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
import sdram_pkg::*;

module sdram_arbiter #(
    parameter int unsigned AddressBitWidth  = 21,
    parameter int unsigned TurnaroundCycles = 1,
    parameter int unsigned MaxGrantCycles   = 1023
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           m0_req,
    output logic                           m0_gnt,
    input  logic                           m0_cmd_en,
    input  logic [2:0]                     m0_cmd,
    input  logic [AddressBitWidth-1:0]     m0_addr,
    input  logic [31:0]                    m0_data,
    input  logic [SdrcDataLenBitWidth-1:0] m0_data_len,
    output logic [31:0]                    m0_rdata,
    output logic                           m0_cmd_ack,

    input  logic                           m1_req,
    output logic                           m1_gnt,
    input  logic                           m1_cmd_en,
    input  logic [2:0]                     m1_cmd,
    input  logic [AddressBitWidth-1:0]     m1_addr,
    input  logic [31:0]                    m1_data,
    input  logic [SdrcDataLenBitWidth-1:0] m1_data_len,
    output logic [31:0]                    m1_rdata,
    output logic                           m1_cmd_ack,

    output logic                           I_sdrc_cmd_en,
    output logic [2:0]                     I_sdrc_cmd,
    output logic [AddressBitWidth-1:0]     I_sdrc_addr,
    output logic [31:0]                    I_sdrc_data,
    output logic [SdrcDataLenBitWidth-1:0] I_sdrc_data_len,
    input  logic [31:0]                    O_sdrc_data,
    input  logic                           O_sdrc_init_done,
    input  logic                           O_sdrc_cmd_ack,

    output logic                           timeout
);

    localparam logic [3:0] TaLast = 4'(TurnaroundCycles - 1);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;
    logic [3:0] ta_cnt_q, ta_cnt_d;
    logic       pick, pick_valid;
    logic       cur_idx, cur_req, release_grant;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [9:0] WdLast = 10'(MaxGrantCycles - 1);
    logic [9:0] wd_cnt_q, wd_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    rr_pick2 u_pick (
        .req_i   ({m1_req, m0_req}),
        .last_i  (last_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        ta_cnt_d      = ta_cnt_q;
        cur_idx       = (state_q == Grant1);
        cur_req       = cur_idx ? m1_req : m0_req;
        release_grant = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            Idle: begin
                if (O_sdrc_init_done && pick_valid) begin
                    state_d = pick ? Grant1 : Grant0;
                    gnt_d   = gnt_onehot(pick);
`ifdef SDRAM_ARB_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            Grant0, Grant1: begin
                if (!cur_req) begin
                    release_grant = 1'b1;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (wd_cnt_q == WdLast) begin
                    release_grant = 1'b1;
                    timeout_d     = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 10'd1;
                end
`endif
                if (release_grant) begin
                    gnt_d    = '0;
                    last_d   = cur_idx;
                    state_d  = Turnaround;
                    ta_cnt_d = '0;
                end
            end
            Turnaround: begin
                if (ta_cnt_q == TaLast) begin
                    state_d = Idle;
                end else begin
                    ta_cnt_d = ta_cnt_q + 4'd1;
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= Idle;
            gnt_q     <= '0;
            last_q    <= 1'b1;
            ta_cnt_q  <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            ta_cnt_q  <= ta_cnt_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign m0_gnt     = gnt_q[0];
    assign m1_gnt     = gnt_q[1];
    assign m0_rdata   = O_sdrc_data;
    assign m1_rdata   = O_sdrc_data;
    assign m0_cmd_ack = O_sdrc_cmd_ack && gnt_q[0];
    assign m1_cmd_ack = O_sdrc_cmd_ack && gnt_q[1];

    // Controller-side fields follow the registered grant only, so an ungranted master never leaks through.
    always_comb begin
        I_sdrc_cmd_en   = (gnt_q[0] && m0_cmd_en) || (gnt_q[1] && m1_cmd_en);
        I_sdrc_cmd      = '0;
        I_sdrc_addr     = '0;
        I_sdrc_data     = '0;
        I_sdrc_data_len = '0;
        if (gnt_q[0]) begin
            I_sdrc_cmd      = m0_cmd;
            I_sdrc_addr     = m0_addr;
            I_sdrc_data     = m0_data;
            I_sdrc_data_len = m0_data_len;
        end else if (gnt_q[1]) begin
            I_sdrc_cmd      = m1_cmd;
            I_sdrc_addr     = m1_addr;
            I_sdrc_data     = m1_data;
            I_sdrc_data_len = m1_data_len;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios then random traffic against a cycle-level reference.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int TURN = 1;
    localparam int MAXG = 16;
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req [2];
    logic        cen [2];
    logic [2:0]  cmd [2];
    logic [20:0] addr [2];
    logic [31:0] wdata [2];
    logic [7:0]  len [2];
    logic [31:0] sdrc_rdata;
    logic        init_done, sdrc_ack;

    logic        m0_gnt, m1_gnt, m0_ack, m1_ack, I_cmd_en, timeout;
    logic [31:0] m0_rdata, m1_rdata, I_data;
    logic [2:0]  I_cmd;
    logic [20:0] I_addr;
    logic [7:0]  I_len;

    int tests = 0;
    int fails = 0;

    // Reference: who owns the port, who was served last, first cycle a new grant may be sampled.
    int owner, last_m, free_at, grant_at, cyc;
    bit to_exp;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .AddressBitWidth (21),
        .TurnaroundCycles(TURN),
        .MaxGrantCycles  (MAXG)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_gnt(m0_gnt), .m0_cmd_en(cen[0]), .m0_cmd(cmd[0]),
        .m0_addr(addr[0]), .m0_data(wdata[0]), .m0_data_len(len[0]),
        .m0_rdata(m0_rdata), .m0_cmd_ack(m0_ack),
        .m1_req(req[1]), .m1_gnt(m1_gnt), .m1_cmd_en(cen[1]), .m1_cmd(cmd[1]),
        .m1_addr(addr[1]), .m1_data(wdata[1]), .m1_data_len(len[1]),
        .m1_rdata(m1_rdata), .m1_cmd_ack(m1_ack),
        .I_sdrc_cmd_en(I_cmd_en), .I_sdrc_cmd(I_cmd), .I_sdrc_addr(I_addr),
        .I_sdrc_data(I_data), .I_sdrc_data_len(I_len),
        .O_sdrc_data(sdrc_rdata), .O_sdrc_init_done(init_done), .O_sdrc_cmd_ack(sdrc_ack),
        .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; last_m = 1; free_at = 0; grant_at = 0; cyc = 0; to_exp = 0;
    endtask

    task automatic model_release();
        last_m  = owner;
        owner   = -1;
        free_at = cyc + TURN + 1;
    endtask

    task automatic model_edge();
        cyc++;
        to_exp = 0;
        if (owner >= 0) begin
            if (!req[owner]) model_release();
            else if (TO_EN && (cyc - grant_at == MAXG)) begin
                model_release();
                to_exp = 1;
            end
        end else if (cyc >= free_at && init_done && (req[0] || req[1])) begin
            if (req[0] && req[1]) owner = (last_m == 0) ? 1 : 0;
            else                  owner = req[0] ? 0 : 1;
            grant_at = cyc;
        end
    endtask

    task automatic check_all();
        logic [1:0] eg;
        int o;
        o  = (owner < 0) ? 0 : owner;
        eg = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
        chk("gnt", 64'({m1_gnt, m0_gnt}), 64'(eg));
        chk("timeout", 64'(timeout), 64'(to_exp));
        chk("cmd_en", 64'(I_cmd_en), 64'((owner >= 0) && cen[o]));
        chk("bus", {I_cmd, I_addr, I_data, I_len},
            (owner >= 0) ? {cmd[o], addr[o], wdata[o], len[o]} : 64'd0);
        chk("rdata", {m0_rdata, m1_rdata}, {sdrc_rdata, sdrc_rdata});
        chk("cmd_ack", 64'({m1_ack, m0_ack}), 64'({sdrc_ack && eg[1], sdrc_ack && eg[0]}));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_gnt", 64'({m1_gnt, m0_gnt}), 64'd0);
        chk("rst_cmd_en", 64'(I_cmd_en), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    function automatic logic [2:0] rand_cmd();
        case ($urandom_range(2))
            0:       return SdrcActivate;
            1:       return SdrcWrite;
            default: return SdrcRead;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            req[i] = 0; cen[i] = 0; cmd[i] = '0; addr[i] = '0; wdata[i] = '0; len[i] = '0;
        end
        init_done  = 1'b1;
        sdrc_ack   = 1'b0;
        sdrc_rdata = 32'hCAFE_0001;
        #2;
        do_reset();

        // Idle with no requests
        repeat (20) tick();

        // Single master, activate visible on the controller port the same cycle as the grant
        cmd[0] = SdrcActivate; addr[0] = 21'h000100; wdata[0] = 32'h1234_5678; len[0] = 8'd7;
        cen[0] = 1'b1; req[0] = 1'b1;
        tick();
        chk("t2_gnt", 64'({m1_gnt, m0_gnt}), 64'b01);
        chk("t2_cmd", 64'(I_cmd), 64'(3'b011));
        chk("t2_addr", 64'(I_addr), 64'h100);
        repeat (10) tick();
        req[0] = 1'b0;
        tick();
        chk("t2_release", 64'(m0_gnt), 64'd0);
        repeat (4) tick();

        // Simultaneous requests, round-robin hand-over
        do_reset();
        req[0] = 1'b1; req[1] = 1'b1;
        tick();
        chk("t3_first", 64'({m1_gnt, m0_gnt}), 64'b01);
        repeat (3) tick();
        req[0] = 1'b0;
        tick();
        repeat (TURN) tick();
        chk("t3_gap", 64'({m1_gnt, m0_gnt}), 64'b00);
        tick();
        chk("t3_m1", 64'({m1_gnt, m0_gnt}), 64'b10);
        req[0] = 1'b1;
        repeat (3) tick();
        req[1] = 1'b0;
        tick();
        req[1] = 1'b1;
        repeat (TURN) tick();
        tick();
        chk("t3_rr", 64'({m1_gnt, m0_gnt}), 64'b01);

        // Ungranted master's command is dropped
        cen[1] = 1'b1; cmd[1] = SdrcWrite; cmd[0] = SdrcRead; sdrc_ack = 1'b1;
        tick();
        chk("t4_cmd", 64'(I_cmd), 64'(3'b101));
        chk("t4_ack1", 64'(m1_ack), 64'd0);
        chk("t4_ack0", 64'(m0_ack), 64'd1);

        // Reset in the middle of a grant
        do_reset();
        req[1] = 1'b0; cen[1] = 1'b0; sdrc_ack = 1'b0;

        // init_done gates new grants only
        init_done = 1'b0; req[0] = 1'b1;
        repeat (8) tick();
        chk("t5_nogrant", 64'({m1_gnt, m0_gnt}), 64'b00);
        init_done = 1'b1;
        tick();
        chk("t5_gnt", 64'({m1_gnt, m0_gnt}), 64'b01);
        init_done = 1'b0;
        repeat (3) tick();
        chk("t5_hold", 64'({m1_gnt, m0_gnt}), 64'b01);
        init_done = 1'b1;

`ifdef SDRAM_ARB_TIMEOUT_EN
        do_reset();
        req[0] = 1'b1;
        tick();
        repeat (MAXG - 1) tick();
        chk("t6_still", 64'(m0_gnt), 64'd1);
        req[1] = 1'b1;
        tick();
        chk("t6_revoke", 64'({m1_gnt, m0_gnt}), 64'b00);
        chk("t6_pulse", 64'(timeout), 64'd1);
        tick();
        chk("t6_pulse_end", 64'(timeout), 64'd0);
        repeat (TURN) tick();
        chk("t6_m1", 64'({m1_gnt, m0_gnt}), 64'b10);
        req[1] = 1'b0; req[0] = 1'b0;
`endif

        // Random traffic
        do_reset();
        for (int unsigned n = 0; n < 400; n++) begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (req[i]) req[i] = ($urandom_range(7) != 0);
                else        req[i] = ($urandom_range(3) == 0);
                cen[i]   = $urandom_range(1);
                cmd[i]   = rand_cmd();
                addr[i]  = 21'($urandom);
                wdata[i] = $urandom;
                len[i]   = 8'($urandom);
            end
            sdrc_ack   = $urandom_range(1);
            sdrc_rdata = $urandom;
            init_done  = ($urandom_range(15) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
